// File: rtl/ads_sample_averager.sv
// rtl/ads_sample_averager.sv - paces ADS1015 conversion requests and block-averages the four electrode channels
module ads_sample_averager #(
    parameter int PERIOD_CYCLES  = 1000,
    parameter int AVG_LOG2       = 3,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear_err,
    input  logic        adc_rdy,
    input  logic [15:0] chA_in,
    input  logic [15:0] chB_in,
    input  logic [15:0] chC_in,
    input  logic [15:0] chD_in,
    output logic        adc_request,
    output logic [15:0] avg_A,
    output logic [15:0] avg_B,
    output logic [15:0] avg_C,
    output logic [15:0] avg_D,
    output logic        avg_valid,
    output logic        timeout_err
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Loaded on the request rise; the 3 covers the IDLE->LOW->LOW->REQ lead-in.
    localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYCLES - 3);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_REQ,
        S_ACC,
        S_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic                     low_cnt_q, low_cnt_d;
    logic [PER_W-1:0]         period_q, period_d;
    logic [TO_W-1:0]          timer_q, timer_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [ACC_W-1:0]  acc_q [4];
    logic signed [ACC_W-1:0]  acc_d [4];
    logic signed [11:0]       samp_q [4];
    logic signed [11:0]       samp_d [4];
    logic [15:0]              avg_q [4];
    logic [15:0]              avg_d [4];
    logic                     avg_valid_q, avg_valid_d;
    logic                     timeout_err_q, timeout_err_d;
    logic [15:0]              ch_in [4];

    assign ch_in[0] = chA_in;
    assign ch_in[1] = chB_in;
    assign ch_in[2] = chC_in;
    assign ch_in[3] = chD_in;

    always_comb begin
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        period_d      = (period_q != '0) ? period_q - PER_W'(1) : period_q;
        timer_d       = timer_q;
        count_d       = count_q;
        avg_valid_d   = 1'b0;
        timeout_err_d = clear_err ? 1'b0 : timeout_err_q;
        for (int i = 0; i < 4; i++) begin
            acc_d[i]  = acc_q[i];
            samp_d[i] = samp_q[i];
            avg_d[i]  = avg_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    count_d = '0;
                    for (int i = 0; i < 4; i++) acc_d[i] = '0;
                end else if (period_q == '0) begin
                    state_d   = S_LOW;
                    low_cnt_d = 1'b0;
                end
            end
            S_LOW: begin
                if (low_cnt_q) begin
                    state_d  = S_REQ;
                    period_d = PER_LOAD;
                    timer_d  = '0;
                end else begin
                    low_cnt_d = 1'b1;
                end
            end
            S_REQ: begin
                if (adc_rdy) begin
                    for (int i = 0; i < 4; i++) samp_d[i] = $signed(ch_in[i][15:4]);
                    state_d = S_ACC;
                end else if (timer_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    count_d       = '0;
                    for (int i = 0; i < 4; i++) acc_d[i] = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            S_ACC: begin
                for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i] + ACC_W'(samp_q[i]);
                count_d = count_q + CNT_W'(1);
                state_d = (count_d == CNT_FULL) ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                // Dropping the low AVG_LOG2 bits of a two's-complement sum floors toward -inf.
                for (int i = 0; i < 4; i++) begin
                    avg_d[i] = {{4{acc_q[i][ACC_W-1]}}, acc_q[i][ACC_W-1:AVG_LOG2]};
                    acc_d[i] = '0;
                end
                avg_valid_d = 1'b1;
                count_d     = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            low_cnt_q     <= 1'b0;
            period_q      <= '0;
            timer_q       <= '0;
            count_q       <= '0;
            avg_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i]  <= '0;
                samp_q[i] <= '0;
                avg_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            period_q      <= period_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            avg_valid_q   <= avg_valid_d;
            timeout_err_q <= timeout_err_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i]  <= acc_d[i];
                samp_q[i] <= samp_d[i];
                avg_q[i]  <= avg_d[i];
            end
        end
    end

    assign adc_request = (state_q == S_REQ);
    assign avg_A       = avg_q[0];
    assign avg_B       = avg_q[1];
    assign avg_C       = avg_q[2];
    assign avg_D       = avg_q[3];
    assign avg_valid   = avg_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ads_sample_averager.sv
// tb/tb_ads_sample_averager.sv - randomized reader model and block-average reference for ads_sample_averager
module tb_ads_sample_averager;

    localparam int P  = 50;
    localparam int L2 = 2;
    localparam int TO = 200;
    localparam int NS = 1 << L2;

    logic        clk = 1'b0;
    logic        rst_n, enable, clear_err, adc_rdy;
    logic [15:0] ch_a, ch_b, ch_c, ch_d;
    logic        adc_request, avg_valid, timeout_err;
    logic [15:0] avg_A, avg_B, avg_C, avg_D;

    ads_sample_averager #(
        .PERIOD_CYCLES (P),
        .AVG_LOG2      (L2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear_err  (clear_err),
        .adc_rdy    (adc_rdy),
        .chA_in     (ch_a),
        .chB_in     (ch_b),
        .chC_in     (ch_c),
        .chD_in     (ch_d),
        .adc_request(adc_request),
        .avg_A      (avg_A),
        .avg_B      (avg_B),
        .avg_C      (avg_C),
        .avg_D      (avg_D),
        .avg_valid  (avg_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: running per-channel sums of 12-bit codes, floor-divided per block.
    int          msum [4];
    int          mcnt = 0;
    int          exp_cyc_q [$];
    logic [63:0] exp_avg_q [$];
    int          exp_next = 0;
    int          valid_cnt = 0;

    function automatic int code_of(input logic [15:0] w);
        int v;
        v = int'(w[15:4]);
        if (v >= 2048) v -= 4096;
        return v;
    endfunction

    function automatic int floor_div(input int s);
        return (s >= 0) ? s / NS : -((-s + NS - 1) / NS);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 4; i++) msum[i] = 0;
        mcnt = 0;
    endtask

    task automatic model_add(input logic [15:0] a, b, c, d, input int r, output bit fin);
        msum[0] += code_of(a);
        msum[1] += code_of(b);
        msum[2] += code_of(c);
        msum[3] += code_of(d);
        mcnt++;
        fin = 1'b0;
        if (mcnt == NS) begin
            exp_cyc_q.push_back(r + 2);
            exp_avg_q.push_back({16'(floor_div(msum[0])), 16'(floor_div(msum[1])),
                                 16'(floor_div(msum[2])), 16'(floor_div(msum[3]))});
            model_flush();
            fin = 1'b1;
        end
    endtask

    int          mon_ec;
    logic [63:0] mon_ea;
    always @(negedge clk) begin
        if (avg_valid) begin
            valid_cnt++;
            if (exp_cyc_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_ec = exp_cyc_q.pop_front();
                mon_ea = exp_avg_q.pop_front();
                check("valid_cycle", cyc, mon_ec);
                check("avg_A", avg_A, mon_ea[63:48]);
                check("avg_B", avg_B, mon_ea[47:32]);
                check("avg_C", avg_C, mon_ea[31:16]);
                check("avg_D", avg_D, mon_ea[15:0]);
            end
        end
    end

    task automatic scramble_inputs();
        ch_a = 16'($urandom);
        ch_b = 16'($urandom);
        ch_c = 16'($urandom);
        ch_d = 16'($urandom);
    endtask

    task automatic wait_rise(output int rc);
        rc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (adc_request) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) check("rise_wait_expired", 0, 1);
    endtask

    task automatic do_conv(input int dly, input logic [15:0] a, b, c, d,
                           input bit chk, input bit drop_en);
        int rc, r;
        bit fin, held;
        wait_rise(rc);
        if (rc < 0) return;
        if (chk) check("rise_cycle", rc, exp_next);
        if (drop_en) enable = 1'b0;
        held = 1'b1;
        for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            if (!adc_request) held = 1'b0;
        end
        check("req_held", held, 1);
        ch_a = a; ch_b = b; ch_c = c; ch_d = d;
        adc_rdy = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        adc_rdy = 1'b0;
        scramble_inputs();
        check("req_fall", adc_request, 0);
        model_add(a, b, c, d, r, fin);
        exp_next = imax(rc + P, r + 4 + int'(fin));
    endtask

    task automatic rand_conv(input int dly, input bit chk);
        do_conv(dly, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), chk, 1'b0);
    endtask

    task automatic inject_idle();
        repeat (3) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            if (!adc_request) begin
                scramble_inputs();
                adc_rdy = 1'b1;
                @(negedge clk);
                adc_rdy = 1'b0;
            end
        end
    endtask

    task automatic do_timeout(input bit hold_clear);
        int rc, n;
        n = 0;
        wait_rise(rc);
        if (rc < 0) return;
        if (hold_clear) clear_err = 1'b1;
        while (adc_request && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_len", n, TO);
        check("timeout_err_set", timeout_err, 1);
        clear_err = 1'b0;
        model_flush();
        exp_next = cyc + 3;
        scramble_inputs();
        adc_rdy = 1'b1;
        @(negedge clk);
        adc_rdy = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("timeout_err_cleared", timeout_err, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int vc, rc, hi;
        logic [11:0] cc [4];
        logic [11:0] dc [4];
        cc[0] = 12'd1; cc[1] = 12'd2; cc[2] = 12'd2; cc[3] = 12'd2;
        dc[0] = 12'hFFF; dc[1] = 12'hFFF; dc[2] = 12'hFFF; dc[3] = 12'hFFE;

        rst_n = 1'b0; enable = 1'b1; clear_err = 1'b0; adc_rdy = 1'b0;
        model_flush();
        scramble_inputs();
        repeat (3) @(negedge clk);
        check("rst_request", adc_request, 0);
        check("rst_valid", avg_valid, 0);
        check("rst_avg_A", avg_A, 0);
        check("rst_avg_B", avg_B, 0);
        check("rst_avg_C", avg_C, 0);
        check("rst_avg_D", avg_D, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        exp_next = cyc + 3;

        vc = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            do_conv(10, 16'h7FF0, 16'h8000, 16'h0010, 16'hFFF0, 1'b1, 1'b0);
            if (i < 3) inject_idle();
        end
        repeat (3) @(negedge clk);
        check("extreme_valid_count", valid_cnt - vc, 1);
        check("extreme_A", avg_A, 16'h07FF);
        check("extreme_B", avg_B, 16'hF800);
        check("extreme_C", avg_C, 16'h0001);
        check("extreme_D", avg_D, 16'hFFFF);

        vc = valid_cnt;
        for (int i = 0; i < 4; i++)
            do_conv(10, 16'($urandom), 16'($urandom), {cc[i], 4'($urandom)},
                    {dc[i], 4'($urandom)}, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("floor_valid_count", valid_cnt - vc, 1);
        check("floor_C", avg_C, 16'h0001);
        check("floor_D", avg_D, 16'hFFFE);

        for (int i = 0; i < 3 * NS; i++) rand_conv($urandom_range(1, 30), 1'b1);

        rand_conv(80, 1'b1);
        rand_conv(80, 1'b1);
        rand_conv(10, 1'b1);
        rand_conv(80, 1'b1);

        rand_conv(10, 1'b1);
        rand_conv(10, 1'b1);
        do_timeout(1'b0);
        pulse_clear();
        for (int i = 0; i < NS; i++) rand_conv(10, 1'b1);
        do_timeout(1'b1);
        pulse_clear();

        rand_conv(12, 1'b1);
        rand_conv(12, 1'b1);
        do_conv(15, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        model_flush();
        hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (adc_request) hi++;
        end
        check("no_request_while_disabled", hi, 0);
        enable = 1'b1;
        exp_next = cyc + 3;
        for (int i = 0; i < NS; i++) rand_conv($urandom_range(1, 20), 1'b1);

        wait_rise(rc);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_request", adc_request, 0);
        check("midrst_valid", avg_valid, 0);
        check("midrst_avg_A", avg_A, 0);
        check("midrst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        model_flush();
        exp_next = cyc + 3;
        for (int i = 0; i < NS; i++) rand_conv($urandom_range(1, 30), 1'b1);

        repeat (4) @(negedge clk);
        check("pending_valid", exp_cyc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ads_sample_averager.md
Name: ads_sample_averager

Overview:
- Downstream consumer and controller of the four-channel ADS1015 I2C reader on the BPM board.
- Issues periodic conversion requests to the reader and captures the four channel words (A-D electrode) on each ready pulse.
- Converts each word to signed 12-bit and block-averages 2^AVG_LOG2 samples per channel.
- Publishes the four averages with a one-cycle valid strobe for the position-calculation stage.

Parameters:
- PERIOD_CYCLES, 1000: target clk cycles between consecutive request rising edges; minimum 8.
- AVG_LOG2, 3: log2 of samples per average (N = 8); legal range 0-6.
- TIMEOUT_CYCLES, 4000: clk cycles request may stay high without adc_rdy before abort.

Ports:
- clk  in  1  slow system clock, same clock as the ADS1015 reader.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  run sampling when high.
- clear_err  in  1  clears timeout_err; sampled per cycle.
- adc_rdy  in  1  one-cycle done pulse from the reader.
- chA_in, chB_in, chC_in, chD_in  in  16 each  reader result words; 12-bit left-justified in [15:4].
- adc_request  out  1  to the reader's request input.
- avg_A, avg_B, avg_C, avg_D  out  16 each  signed averages, sign-extended from 12 bits.
- avg_valid  out  1  one-cycle strobe on update.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset, rst_n low at a clk edge: all outputs 0; FSM in S_IDLE; accumulators, sample count and period counter cleared. Period counter 0 means the first request may start at once.
- States: S_IDLE, S_LOW, S_REQ, S_ACC, S_OUT.
- S_IDLE: adc_request = 0. Goes to S_LOW when enable = 1 and the period counter has expired. While enable = 0, accumulators and sample count are cleared every cycle.
- S_LOW: adc_request = 0 for exactly 2 cycles, so the reader's idle state sees request low. Then goes to S_REQ.
- S_REQ: adc_request = 1.
  - adc_rdy = 1: register all four inputs; go to S_ACC.
  - Otherwise, after TIMEOUT_CYCLES cycles in S_REQ: set timeout_err, clear accumulators and count, go to S_IDLE.
- adc_rdy is ignored in every state except S_REQ, including a late pulse after a timeout.
- Conversion: sample = signed in[15:4], giving -2048..2047. in[3:0] is ignored.
- S_ACC, 1 cycle: acc_X += sample for each channel; accumulators are signed, 12+AVG_LOG2 bits wide, and cannot overflow. count += 1.
  - count reaches 2^AVG_LOG2: go to S_OUT.
  - Otherwise: go to S_IDLE.
- S_OUT, 1 cycle: avg_X = sign-extend(acc_X >>> AVG_LOG2), an arithmetic shift that floors toward minus infinity. avg_valid = 1 this cycle only. Clear accumulators and count; go to S_IDLE.
- Latency: avg_valid is high 2 cycles after the clk edge that samples the final adc_rdy. avg_X holds until the next S_OUT or reset.
- Period:
  - Consecutive adc_request rising edges are exactly PERIOD_CYCLES apart when the conversion ends early enough.
  - Otherwise the next rise comes 4 cycles after the adc_rdy sample edge (S_ACC, S_IDLE, 2x S_LOW). Never sooner.
- timeout_err: cleared by reset or clear_err = 1. If timeout and clear_err occur in the same cycle, the set wins.
- enable falling mid-conversion: the current S_REQ completes or times out normally, and the sample is accumulated. No new request starts; the partial block is then discarded in S_IDLE.
- rst_n low mid-operation: immediate return to the reset state next edge; adc_request drops the same edge.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with enable = 1 → adc_request = 0, avg_* = 0, avg_valid = 0, timeout_err = 0; first request rise 3 cycles after release.
- Extremes (AVG_LOG2 = 2, reader model answers rdy 10 cycles after request). Inputs each sample: A = 16'h7FF0, B = 16'h8000, C = 16'h0010, D = 16'hFFF0, four samples → exactly one avg_valid; avg_A = 16'h07FF, avg_B = 16'hF800, avg_C = 16'h0001, avg_D = 16'hFFFF.
- Floor rounding (AVG_LOG2 = 2). Inputs:
  - C codes 1, 2, 2, 2 → avg_C = 16'h0001.
  - D codes -1, -1, -1, -2 → avg_D = 16'hFFFE.
  - Nonzero in[3:0] → no effect.
- Timing (PERIOD_CYCLES = 50):
  - rdy after 10 cycles → request rises spaced 50 cycles.
  - rdy after 80 cycles → next rise 4 cycles after rdy.
  - rdy pulses during S_IDLE/S_LOW → ignored.
- Timeout (TIMEOUT_CYCLES = 200, model never responds) → request falls after 200 high cycles; timeout_err = 1; partial sums discarded.
  - Late rdy → ignored.
  - clear_err pulse → flag clears.
  - Timeout and clear_err together → flag stays 1.
- Enable drop after 2 of 4 samples, re-enable → no avg_valid until 4 fresh samples; in-flight conversion finishes and request stays low.
